gyro_data_formatter: RTL

Converts the 16-bit axis/temperature word chosen by the PmodGYRO data selector into sign-magnitude BCD for the seven-segment display driver. It sits directly downstream of the selector and directly upstream of the display multiplexer. Conversion is iterative double-dabble: one bit per clock, with a start/done handshake. Axis words are treated as 16-bit two's complement. The temperature word (sel = 2'b11) is treated as 8-bit two's complement held in data[7:0].

---
 rtl/gyro_data_formatter_pkg.sv | 15 +
 rtl/gyro_data_formatter_if.sv | 15 +
 rtl/gyro_data_formatter_adj.sv | 7 +
 rtl/gyro_data_formatter.sv | 96 +++++++++
 4 files changed

// File: rtl/gyro_data_formatter_pkg.sv
// Shared widths, state encoding and selector codes for the gyro BCD formatter.
package gyro_fmt_pkg;
   localparam int DATA_W = 16;
   localparam int MAG_W  = 17;
   localparam int N_DIG  = 5;
   localparam int N_ITER = 17;
   localparam int BCD_W  = 4 * N_DIG;

   localparam logic [1:0] SEL_TEMP = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CONV = 1'b1
   } state_t;
endpackage

// File: rtl/gyro_data_formatter_if.sv
// Request/result bundle between the data selector, the formatter and the display mux.
interface gyro_data_formatter_if;
   import gyro_fmt_pkg::*;

   logic              start;
   logic [DATA_W-1:0] data;
   logic [1:0]        sel;
   logic              busy;
   logic              done;
   logic              sign;
   logic [BCD_W-1:0]  bcd;

   modport master (output start, data, sel, input busy, done, sign, bcd);
   modport slave  (input start, data, sel, output busy, done, sign, bcd);
endinterface

// File: rtl/gyro_data_formatter_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before a shift.
module bcd_digit_adj (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/gyro_data_formatter.sv
// Sign-magnitude BCD conversion of a selected gyro axis/temperature word,
// one double-dabble step per clock with a start/done handshake.
module gyro_data_formatter
   import gyro_fmt_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   gyro_data_formatter_if.slave bus
);
   localparam logic [4:0] LAST_CNT = 5'(N_ITER - 1);

   state_t           state, state_nxt;
   logic             capture, last;
   logic [4:0]       count;
   logic [MAG_W-1:0] mag, ext, mag_in;
   logic [BCD_W-1:0] bcd_shift, bcd_adj, shift_nxt;
   logic             sign_q;
   logic             busy_q, done_q, sign_o;
   logic [BCD_W-1:0] bcd_o;

   // Temperature lives in the low byte; everything is widened to 17 bits so
   // that negating -32768 still fits.
   always_comb begin
      ext    = (bus.sel == SEL_TEMP) ? {{(MAG_W-8){bus.data[7]}}, bus.data[7:0]}
                                     : {bus.data[DATA_W-1], bus.data};
      mag_in = ext[MAG_W-1] ? -ext : ext;
   end

   for (genvar g = 0; g < N_DIG; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (bcd_shift[4*g +: 4]),
         .dout (bcd_adj[4*g +: 4])
      );
   end

   assign shift_nxt = {bcd_adj[BCD_W-2:0], mag[MAG_W-1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      last      = 1'b0;
      case (state)
         ST_IDLE: if (bus.start) begin
            capture   = 1'b1;
            state_nxt = ST_CONV;
         end
         ST_CONV: if (count == LAST_CNT) begin
            last      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag       <= '0;
         bcd_shift <= '0;
         count     <= '0;
         sign_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sign_o    <= 1'b0;
         bcd_o     <= '0;
      end else begin
         done_q <= last;
         if (capture) begin
            mag       <= mag_in;
            sign_q    <= ext[MAG_W-1];
            bcd_shift <= '0;
            count     <= '0;
            busy_q    <= 1'b1;
         end else if (state == ST_CONV) begin
            bcd_shift <= shift_nxt;
            mag       <= {mag[MAG_W-2:0], 1'b0};
            count     <= count + 5'd1;
            // Final step publishes the freshly shifted digits directly.
            if (last) begin
               bcd_o  <= shift_nxt;
               sign_o <= sign_q;
               busy_q <= 1'b0;
            end
         end
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sign = sign_o;
   assign bus.bcd  = bcd_o;
endmodule
